// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet transmit sequencer.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    HDR,
    PAY,
    PAD,
    FCS,
    IFG
  } tx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam int          PREAMBLE_LEN = 7;
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

  // One bit step of the reflected CRC-32 shift register.
  function automatic logic [31:0] crc_shift1(input logic [31:0] c);
    return c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Registered CRC-32 (reflected) that absorbs one byte per enabled cycle.
module eth_crc32_byte
  import eth_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_reg;
  logic [31:0] stage [0:8];

  assign stage[0] = crc_reg ^ {24'd0, data};

  // Unrolled eight-step bitwise update, LSB of the byte first.
  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    assign stage[gi+1] = crc_shift1(stage[gi]);
  end

  // CRC register: init wins over en so a new frame always starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg <= CRC_INIT;
    end else if (init) begin
      crc_reg <= CRC_INIT;
    end else if (en) begin
      crc_reg <= stage[8];
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/eth_tx_sequencer.sv
// Frame-level transmit scheduler: preamble/SFD, header, payload, pad, FCS, IFG.
module eth_tx_sequencer #(
  parameter int MIN_FRAME = 60,
  parameter int MAX_FRAME = 1514,
  parameter int IFG_BYTES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  hdr_data,
  input  logic        hdr_valid,
  input  logic        hdr_last,
  output logic        hdr_ready,
  input  logic [7:0]  pay_data,
  input  logic        pay_valid,
  input  logic        pay_last,
  output logic        pay_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] frame_count
);
  import eth_tx_pkg::*;

  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME);
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

  tx_state_t   state_reg;
  logic [10:0] byte_cnt_reg;
  logic [10:0] byte_cnt_next;
  logic [15:0] aux_cnt_reg;     // preamble index, FCS byte index or IFG cycle
  logic [7:0]  tx_data_reg;
  logic        tx_valid_reg;
  logic        done_reg;
  logic        err_reg;
  logic [15:0] frame_count_reg;

  logic        crc_init;
  logic        crc_en;
  logic [7:0]  crc_data;
  logic [31:0] crc_value;
  logic [7:0]  fcs_byte;

  assign byte_cnt_next = byte_cnt_reg + 11'd1;

  // CRC feed: restart during SFD, absorb every accepted or padded byte.
  always_comb begin
    crc_init = (state_reg == SFD);
    crc_en   = 1'b0;
    crc_data = 8'h00;
    case (state_reg)
      HDR: begin
        crc_en   = hdr_valid;
        crc_data = hdr_data;
      end
      PAY: begin
        crc_en   = pay_valid;
        crc_data = pay_data;
      end
      PAD: crc_en = 1'b1;
      default: ;
    endcase
  end

  eth_crc32_byte u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .data (crc_data),
    .crc  (crc_value)
  );

  // FCS is the inverted CRC, least-significant byte on the wire first.
  always_comb begin
    case (aux_cnt_reg[1:0])
      2'd0:    fcs_byte = ~crc_value[7:0];
      2'd1:    fcs_byte = ~crc_value[15:8];
      2'd2:    fcs_byte = ~crc_value[23:16];
      default: fcs_byte = ~crc_value[31:24];
    endcase
  end

  // Frame sequencing state machine; tx byte, strobes and counters are registered.
  // An abort enters IFG one count ahead so the idle gap matches a clean frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      byte_cnt_reg    <= '0;
      aux_cnt_reg     <= '0;
      tx_data_reg     <= '0;
      tx_valid_reg    <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            tx_data_reg  <= ETH_PREAMBLE;
            tx_valid_reg <= 1'b1;
            aux_cnt_reg  <= 16'd1;
            state_reg    <= PRE;
          end
        end
        PRE: begin
          tx_data_reg  <= ETH_PREAMBLE;
          tx_valid_reg <= 1'b1;
          aux_cnt_reg  <= aux_cnt_reg + 16'd1;
          if (aux_cnt_reg >= PRE_LAST) begin
            state_reg <= SFD;
          end
        end
        SFD: begin
          tx_data_reg  <= ETH_SFD;
          tx_valid_reg <= 1'b1;
          byte_cnt_reg <= '0;
          state_reg    <= HDR;
        end
        HDR: begin
          if (!hdr_valid || (byte_cnt_next > MAX_CNT && !hdr_last)) begin
            err_reg     <= 1'b1;
            aux_cnt_reg <= 16'd1;
            state_reg   <= IFG;
          end else begin
            tx_data_reg  <= hdr_data;
            tx_valid_reg <= 1'b1;
            byte_cnt_reg <= byte_cnt_next;
            if (hdr_last) begin
              state_reg <= PAY;
            end
          end
        end
        PAY: begin
          if (!pay_valid || (byte_cnt_next > MAX_CNT && !pay_last)) begin
            err_reg     <= 1'b1;
            aux_cnt_reg <= 16'd1;
            state_reg   <= IFG;
          end else begin
            tx_data_reg  <= pay_data;
            tx_valid_reg <= 1'b1;
            byte_cnt_reg <= byte_cnt_next;
            if (pay_last) begin
              aux_cnt_reg <= '0;
              state_reg   <= (byte_cnt_next < MIN_CNT) ? PAD : FCS;
            end
          end
        end
        PAD: begin
          tx_data_reg  <= 8'h00;
          tx_valid_reg <= 1'b1;
          byte_cnt_reg <= byte_cnt_next;
          if (byte_cnt_next >= MIN_CNT) begin
            aux_cnt_reg <= '0;
            state_reg   <= FCS;
          end
        end
        FCS: begin
          tx_data_reg  <= fcs_byte;
          tx_valid_reg <= 1'b1;
          if (aux_cnt_reg[1:0] == 2'd3) begin
            done_reg        <= 1'b1;
            frame_count_reg <= frame_count_reg + 16'd1;
            aux_cnt_reg     <= '0;
            state_reg       <= IFG;
          end else begin
            aux_cnt_reg <= aux_cnt_reg + 16'd1;
          end
        end
        IFG: begin
          if (aux_cnt_reg >= IFG_LAST) begin
            state_reg <= IDLE;
          end else begin
            aux_cnt_reg <= aux_cnt_reg + 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign hdr_ready   = (state_reg == HDR);
  assign pay_ready   = (state_reg == PAY);
  assign busy        = (state_reg != IDLE);
  assign tx_data     = tx_data_reg;
  assign tx_valid    = tx_valid_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_eth_tx_sequencer.sv
// Randomized bench: two sequencer instances (default limits, and MIN=0/MAX=64)
// checked against a byte-stream reference model built from the frame rules.
module tb_eth_tx_sequencer;

  localparam int IFG = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]      start = '0, hdr_valid = '0, hdr_last = '0, pay_valid = '0, pay_last = '0;
  logic [1:0][7:0] hdr_data = '0, pay_data = '0;
  logic [1:0]      hdr_ready, pay_ready, tx_valid, busy, done, err;
  logic [1:0][7:0] tx_data;
  logic [1:0][15:0] frame_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0]  hbuf [0:255];
  logic [7:0]  pbuf [0:255];
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  logic [15:0] fc_model [0:1];

  always #4 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    eth_tx_sequencer #(
      .MIN_FRAME ((gi == 0) ? 60 : 0),
      .MAX_FRAME ((gi == 0) ? 1514 : 64),
      .IFG_BYTES (IFG)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start[gi]),
      .hdr_data    (hdr_data[gi]),
      .hdr_valid   (hdr_valid[gi]),
      .hdr_last    (hdr_last[gi]),
      .hdr_ready   (hdr_ready[gi]),
      .pay_data    (pay_data[gi]),
      .pay_valid   (pay_valid[gi]),
      .pay_last    (pay_last[gi]),
      .pay_ready   (pay_ready[gi]),
      .tx_data     (tx_data[gi]),
      .tx_valid    (tx_valid[gi]),
      .busy        (busy[gi]),
      .done        (done[gi]),
      .err         (err[gi]),
      .frame_count (frame_count[gi])
    );
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int min_of(input int u);
    return (u == 0) ? 60 : 0;
  endfunction

  function automatic int max_of(input int u);
    return (u == 0) ? 1514 : 64;
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      hbuf[i] = 8'($urandom);
      pbuf[i] = 8'($urandom);
    end
  endtask

  // Expected wire bytes for one frame, straight from the framing rules.
  task automatic build_expect(input int u, input int hlen, input int plen, input int cut,
                              input bit no_last, output bit aborted);
    int          total, nd;
    logic [31:0] crc;
    logic [7:0]  b;
    bit          is_last;
    total   = no_last ? 256 : hlen + plen;
    crc     = 32'hFFFFFFFF;
    nd      = 0;
    aborted = 1'b0;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < total; i++) begin
      b       = (i < hlen) ? hbuf[i] : pbuf[(i - hlen) % 256];
      is_last = (i == hlen - 1) || (!no_last && i == total - 1);
      if (i == cut || ((i + 1) > max_of(u) && !is_last)) begin
        aborted = 1'b1;
        break;
      end
      exp_q.push_back(b);
      crc = crc_byte(crc, b);
      nd++;
    end
    if (!aborted) begin
      while (nd < min_of(u)) begin
        exp_q.push_back(8'h00);
        crc = crc_byte(crc, 8'h00);
        nd++;
      end
      crc = ~crc;
      for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
    end
  endtask

  // Drive one frame on instance u, trace outputs at negedge, then score the trace.
  task automatic run_frame(input int u, input int hlen, input int plen, input int cut,
                           input bit no_last, input bit keep_start, input bit chained,
                           input bit rst_in_pay);
    int done_idx[$], err_idx[$];
    int n, hidx, pidx, di, first_v, last_v, end_idx, nbz;
    bit finished, seen_end, aborted;
    n = 0; hidx = 0; pidx = 0; first_v = -1; last_v = -1; end_idx = 0; nbz = 0;
    finished = 1'b0; seen_end = 1'b0;
    obs_q.delete();
    while (!finished && n < 4000) begin
      @(negedge clk);
      if (tx_valid[u]) begin
        obs_q.push_back(tx_data[u]);
        if (first_v < 0) first_v = n;
        last_v = n;
      end
      if (done[u]) done_idx.push_back(n);
      if (err[u]) err_idx.push_back(n);
      if (done[u] || err[u]) seen_end = 1'b1;
      if (!busy[u]) nbz++;
      if (seen_end && !busy[u]) begin
        finished = 1'b1;
        end_idx  = n;
      end
      di           = hidx + pidx;
      start[u]     = (n == 0) || keep_start;
      hdr_data[u]  = hbuf[(hidx < hlen) ? hidx : 0];
      hdr_valid[u] = (di != cut);
      hdr_last[u]  = (hidx == hlen - 1);
      pay_data[u]  = pbuf[pidx % 256];
      pay_valid[u] = (di != cut);
      pay_last[u]  = !no_last && (pidx == plen - 1);
      if (hdr_ready[u] && hdr_valid[u]) hidx++;
      if (pay_ready[u] && pay_valid[u]) pidx++;
      if (rst_in_pay && pay_ready[u] && pidx >= 3) begin
        rst      = 1'b1;
        finished = 1'b1;
      end
      n++;
    end
    hdr_valid[u] = 1'b0; hdr_last[u] = 1'b0; pay_valid[u] = 1'b0; pay_last[u] = 1'b0;
    check_eq("timeout", int'(finished), 1);
    if (rst_in_pay) begin
      start[u] = 1'b0;
      @(negedge clk);
      for (int v = 0; v < 2; v++) begin
        check_eq("rst_tx_valid", int'(tx_valid[v]), 0);
        check_eq("rst_tx_data", int'(tx_data[v]), 0);
        check_eq("rst_ready", int'({hdr_ready[v], pay_ready[v]}), 0);
        check_eq("rst_busy", int'(busy[v]), 0);
        check_eq("rst_strobes", int'({done[v], err[v]}), 0);
        check_eq("rst_fcount", int'(frame_count[v]), 0);
        fc_model[v] = '0;
      end
      rst = 1'b0;
      $display("frame u=%0d reset during payload after %0d payload bytes", u, pidx);
      return;
    end
    if (!keep_start) start[u] = 1'b0;
    build_expect(u, hlen, plen, cut, no_last, aborted);
    if (!aborted) fc_model[u] = fc_model[u] + 16'd1;
    check_eq("lead", first_v, chained ? 0 : 1);
    check_eq("len", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("byte%0d", i), int'(obs_q[i]), int'(exp_q[i]));
    check_eq("contig", last_v - first_v + 1, exp_q.size());
    check_eq("done_n", done_idx.size(), aborted ? 0 : 1);
    if (!aborted && done_idx.size() == 1) check_eq("done_at", done_idx[0], last_v);
    check_eq("err_n", err_idx.size(), aborted ? 1 : 0);
    if (aborted && err_idx.size() == 1) check_eq("err_at", err_idx[0], last_v + 1);
    check_eq("gap", end_idx - last_v, IFG);
    check_eq("busy_idle", nbz, chained ? 1 : 2);
    check_eq("fcount", int'(frame_count[u]), int'(fc_model[u]));
    $display("frame u=%0d hlen=%0d plen=%0d cut=%0d nolast=%0d bytes=%0d aborted=%0d count=%0d",
             u, hlen, plen, cut, no_last, obs_q.size(), aborted, frame_count[u]);
  endtask

  initial begin
    logic [7:0] ref_fcs [0:3];
    int pl;
    ref_fcs[0] = 8'h26; ref_fcs[1] = 8'h39; ref_fcs[2] = 8'hF4; ref_fcs[3] = 8'hCB;
    fc_model[0] = '0;
    fc_model[1] = '0;

    // Reset state on both instances while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int v = 0; v < 2; v++) begin
      check_eq("reset_tx", int'({tx_valid[v], tx_data[v]}), 0);
      check_eq("reset_ctl", int'({hdr_ready[v], pay_ready[v], busy[v], done[v], err[v]}), 0);
      check_eq("reset_fcount", int'(frame_count[v]), 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Known check value: "123456789" with no padding.
    fill_random();
    for (int i = 0; i < 5; i++) hbuf[i] = 8'h31 + 8'(i);
    for (int i = 0; i < 4; i++) pbuf[i] = 8'h36 + 8'(i);
    run_frame(1, 5, 4, -1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      check_eq("known_fcs", (obs_q.size() >= 4) ? int'(obs_q[obs_q.size() - 4 + k]) : -1,
               int'(ref_fcs[k]));
    check_eq("known_fcount", int'(frame_count[1]), 1);

    // Short frame padded to the minimum length.
    fill_random();
    run_frame(0, 42, 4, -1, 0, 0, 0, 0);
    check_eq("padded_len", obs_q.size(), 72);

    // Header underrun after 10 bytes, then a clean frame.
    fill_random();
    run_frame(0, 20, 10, 10, 0, 0, 0, 0);
    fill_random();
    run_frame(0, 14, 50, -1, 0, 0, 0, 0);

    // Payload without last runs past the 64-byte limit.
    fill_random();
    run_frame(1, 14, 200, -1, 1, 0, 0, 0);

    // Back-to-back frames with start held high.
    for (int f = 0; f < 3; f++) begin
      fill_random();
      pl = $urandom_range(4, 30);
      run_frame(0, 42, pl, -1, 0, (f < 2), (f > 0), 0);
    end

    // Random frames on both instances, some with underruns.
    for (int t = 0; t < 12; t++) begin
      int u, hl, pln, ct;
      u   = $urandom_range(0, 1);
      hl  = $urandom_range(1, 40);
      pln = $urandom_range(1, 90);
      ct  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, hl + pln - 1) : -1;
      fill_random();
      run_frame(u, hl, pln, ct, 0, 0, 0, 0);
    end

    // Reset in the middle of a payload, then a clean frame.
    fill_random();
    run_frame(0, 20, 30, -1, 0, 0, 0, 1);
    fill_random();
    run_frame(0, 20, 30, -1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/eth_tx_sequencer.md
Name: eth_tx_sequencer

Overview:
Frame-level transmit scheduler that sits between the header generator chain and the RGMII transmit module. It sequences preamble/SFD, the header byte stream, the payload byte stream, zero padding to minimum length, the FCS and the inter-frame gap. It computes the Ethernet CRC itself, driving one byte per tx clock to the RGMII transmit module with a valid/ready pull handshake on both sources.

Parameters:
MIN_FRAME, 60, minimum bytes from first header byte to last pad byte (FCS excluded); 0 disables padding
MAX_FRAME, 1514, byte-count limit (FCS excluded); exceeding it aborts the frame
IFG_BYTES, 12, idle cycles after FCS or abort before the next start is accepted

Ports:
clk  in  1  125 MHz tx clock; the only clock
rst  in  1  reset, synchronous, active-high
start  in  1  request one frame; sampled only in IDLE
hdr_data  in  8  header byte (Ethernet+IP+UDP)
hdr_valid  in  1  hdr_data valid
hdr_last  in  1  final header byte
hdr_ready  out  1  sequencer pulls a header byte
pay_data  in  8  payload byte
pay_valid  in  1  pay_data valid
pay_last  in  1  final payload byte
pay_ready  out  1  sequencer pulls a payload byte
tx_data  out  8  byte to RGMII transmit module
tx_valid  out  1  tx_data valid
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on the cycle the last FCS byte is on tx_data
err  out  1  one-cycle pulse on abort
frame_count  out  16  completed frames; wraps 0xFFFF->0

Behaviour:
- Reset: state IDLE. tx_data=0, tx_valid=0, hdr_ready=0, pay_ready=0, busy=0, done=0, err=0, frame_count=0. Reset applies at the next edge, including mid-frame: tx_valid is 0 from that edge, and no FCS or IFG follows.
- tx_data and tx_valid are registered. hdr_ready is high exactly while in HDR. pay_ready is high exactly while in PAY. Both are decoded from state only.
- A byte is accepted when valid and ready are high on the same edge. It appears on tx_data on the following cycle.
- States:
  - IDLE: on start=1, go to PRE. The cycle after start is sampled, tx_data=0x55.
  - PRE: 7 bytes of 0x55, then SFD.
  - SFD: 1 byte of 0xD5, then HDR.
  - HDR: pull header bytes. If hdr_last is accepted, go to PAY.
  - PAY: pull payload bytes. If pay_last is accepted: when the byte count < MIN_FRAME go to PAD, otherwise go to FCS. Payload is at least 1 byte.
  - PAD: emit 0x00 until the byte count equals MIN_FRAME, then FCS.
  - FCS: 4 bytes. done pulses with the 4th byte, and frame_count increments on the same cycle. Then IFG.
  - IFG: tx_valid=0 for IFG_BYTES cycles, then IDLE.
- Byte count: 11 bits. It counts every HDR/PAY/PAD byte, reset at SFD.
- CRC: CRC-32, reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF in SFD, updated on every HDR/PAY/PAD byte. FCS = ~crc, sent least-significant byte first.
- Underrun (valid=0 while in HDR or PAY): abort. Next cycle tx_valid=0, err pulses, then IFG; frame_count unchanged.
- Overflow: if an accepted byte makes the count exceed MAX_FRAME without being last, the same abort path applies.
- start is ignored outside IDLE; there is no queueing. hdr_* and pay_* inputs are ignored outside HDR and PAY.

Decomposition:
- Package eth_tx_pkg holds:
  - state enum: IDLE, PRE, SFD, HDR, PAY, PAD, FCS, IFG
  - constants: ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, PREAMBLE_LEN=7, CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF
- One sub-module, eth_crc32_byte: registered CRC with init and en inputs, an 8-bit data input and a 32-bit crc output. It performs a one-byte update per enabled cycle and is instantiated once.

Test Plan:
1. MIN_FRAME=0; header "12345", payload "6789" (ASCII); start -> 7x55, D5, the 9 data bytes, then FCS 26 39 F4 CB. done pulses on CB, frame_count=1, then 12 cycles with tx_valid=0.
2. Defaults; 42-byte header + 4-byte payload -> 14 bytes of 0x00 padding (count=60), 4 FCS bytes, 72 tx_valid cycles total. FCS matches the reference model.
3. hdr_valid dropped after 10 header bytes -> tx_valid=0 the next cycle, err pulses once, no done, frame_count unchanged. After 12 idle cycles busy=0 and a new start succeeds.
4. MAX_FRAME=64; payload streamed without pay_last past 64 bytes -> abort on byte 65, err pulses.
5. start held high continuously; back-to-back 60-byte frames -> exactly 12 idle cycles between the last FCS byte and the next 0x55. start during a frame is never double-counted.
6. rst asserted in PAY -> next cycle all outputs at reset values and frame_count=0. The next start produces a clean frame.
